// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Purpose: bundles the pipeline request/response handshake and the word-wide
//          data memory port of the MEM-stage load/store initiator.
// Signals:
//   request  : reqValid, reqReady, reqWrite, reqSize, reqSigned, reqAddr, reqWData
//   response : respValid, loadData, alignErr
//   memory   : memAddr, memWData, memRead, memWrite, readDataMem
// Modports:
//   slave  - the controller (consumes requests, drives the memory port)
//   master - the environment (pipeline plus memory model)
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_BITS = 32
);

  logic                 reqValid;
  logic                 reqReady;
  logic                 reqWrite;
  logic [1:0]           reqSize;
  logic                 reqSigned;
  logic [31:0]          reqAddr;
  logic [31:0]          reqWData;

  logic                 respValid;
  logic [31:0]          loadData;
  logic                 alignErr;

  logic [ADDR_BITS-1:0] memAddr;
  logic [31:0]          memWData;
  logic                 memRead;
  logic                 memWrite;
  logic [31:0]          readDataMem;

  modport slave (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, readDataMem,
    output reqReady, respValid, loadData, alignErr, memAddr, memWData, memRead, memWrite
  );

  modport master (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, readDataMem,
    input  reqReady, respValid, loadData, alignErr, memAddr, memWData, memRead, memWrite
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Purpose: MEM-stage load/store initiator. Accepts byte/half/word requests,
//          performs loads with lane extraction and sign/zero extension, does
//          sub-word stores as read-modify-write, and reports misaligned or
//          reserved-size requests without touching memory.
// Ports:
//   clk    - clock, all state on posedge
//   reset  - synchronous, active-high reset
//   bus    - mem_access_ctrl_if.slave (request, response and memory port)
// Parameters:
//   ADDR_BITS - width of the memory word-index address (memAddr)
//   DATA_BITS - memory word width; only 32 is supported
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_ctrl_if.slave   bus
);

  localparam int unsigned SIZE_BYTE = 0;
  localparam int unsigned SIZE_HALF = 1;
  localparam int unsigned SIZE_WORD = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t      state_q;

  // Request fields latched at accept; memAddr itself holds the word index.
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [15:0] wdata_q;

  logic [DATA_BITS-1:0] rdata_c;
  logic                 misalign_c;
  logic [ADDR_BITS-1:0] word_idx_c;

  // Pick the addressed lane (little-endian) and extend it to a full word.
  function automatic logic [31:0] extract_lane(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'(SIZE_BYTE): r = {{24{sgn & b[7]}}, b};
      2'(SIZE_HALF): r = {{16{sgn & h[15]}}, h};
      default:       r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of a word with right-justified store data.
  function automatic logic [31:0] merge_lane(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic [15:0] wd
  );
    logic [31:0] r;
    r = word;
    if (size == 2'(SIZE_BYTE)) begin
      r[{off, 3'b000} +: 8] = wd[7:0];
    end else if (off[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  // Request decode: alignment check and word index of the incoming address.
  always_comb begin
    rdata_c    = bus.readDataMem;
    word_idx_c = ADDR_BITS'(bus.reqAddr[31:2]);
    misalign_c = 1'b0;
    case (bus.reqSize)
      2'(SIZE_BYTE): misalign_c = 1'b0;
      2'(SIZE_HALF): misalign_c = bus.reqAddr[0];
      2'(SIZE_WORD): misalign_c = (bus.reqAddr[1:0] != 2'b00);
      default:       misalign_c = 1'b1;
    endcase
  end

  // Access sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      off_q         <= 2'b00;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      wdata_q       <= 16'h0;
      bus.reqReady  <= 1'b1;
      bus.respValid <= 1'b0;
      bus.alignErr  <= 1'b0;
      bus.loadData  <= 32'h0;
      bus.memAddr   <= '0;
      bus.memWData  <= 32'h0;
      bus.memRead   <= 1'b0;
      bus.memWrite  <= 1'b0;
    end else begin
      bus.respValid <= 1'b0;
      bus.alignErr  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.reqValid) begin
            off_q        <= bus.reqAddr[1:0];
            size_q       <= bus.reqSize;
            signed_q     <= bus.reqSigned;
            wdata_q      <= bus.reqWData[15:0];
            bus.reqReady <= 1'b0;
            if (misalign_c) begin
              // No memory access: report straight away.
              bus.respValid <= 1'b1;
              bus.alignErr  <= 1'b1;
              state_q       <= S_RESP;
            end else begin
              bus.memAddr <= word_idx_c;
              if (!bus.reqWrite) begin
                bus.memRead <= 1'b1;
                state_q     <= S_LOAD;
              end else if (bus.reqSize == 2'(SIZE_WORD)) begin
                bus.memWData <= bus.reqWData;
                bus.memWrite <= 1'b1;
                state_q      <= S_STORE;
              end else begin
                bus.memRead <= 1'b1;
                state_q     <= S_RMW_RD;
              end
            end
          end
        end

        S_LOAD: begin
          bus.memRead   <= 1'b0;
          bus.loadData  <= extract_lane(rdata_c, off_q, size_q, signed_q);
          bus.respValid <= 1'b1;
          state_q       <= S_RESP;
        end

        S_STORE: begin
          bus.memWrite  <= 1'b0;
          bus.respValid <= 1'b1;
          state_q       <= S_RESP;
        end

        S_RMW_RD: begin
          // Read and write strobes never overlap: drop read as write rises.
          bus.memRead  <= 1'b0;
          bus.memWData <= merge_lane(rdata_c, off_q, size_q, wdata_q);
          bus.memWrite <= 1'b1;
          state_q      <= S_RMW_WR;
        end

        S_RMW_WR: begin
          bus.memWrite  <= 1'b0;
          bus.respValid <= 1'b1;
          state_q       <= S_RESP;
        end

        S_RESP: begin
          bus.reqReady <= 1'b1;
          state_q      <= S_IDLE;
        end

        default: begin
          bus.memRead  <= 1'b0;
          bus.memWrite <= 1'b0;
          bus.reqReady <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Purpose: self-checking bench for mem_access_ctrl. A word memory model sits on
//          the memory port; expectations come from a directed table, a couple
//          of hand-written reset sequences, and a byte-addressed reference
//          model for randomized traffic.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word memory: async read, write at posedge while memWrite is high.
  logic [31:0] mem [64];
  assign bus.readDataMem = mem[bus.memAddr[5:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (bus.memWrite) begin
      mem[bus.memAddr[5:0]] <= bus.memWData;
    end
  end

  // Reference model: plain byte array plus last load result.
  logic [7:0]  refm [256];
  logic [31:0] ref_ld;

  int checks;
  int errors;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] ld;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
    logic [31:0] maddr;
    bit          both;
    bit          stable;
    bit          post_ok;
  } obs_t;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wdat;
    int          lat;
    logic        err;
    logic [31:0] ld;
    int          nrd;
    int          nwr;
    logic [31:0] mwd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {refm[4*idx+3], refm[4*idx+2], refm[4*idx+1], refm[4*idx]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sg);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v + (32'(refm[a + 32'(i)]) << (8 * i));
    if (sg && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wdat);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) refm[a + 32'(i)] = 8'((wdat >> (8 * i)) & 32'hFF);
  endtask

  // Issue one request and observe the whole access until one cycle after respValid.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wdat, output obs_t o);
    int  g;
    bit  have;
    o = '{default: 0};
    o.stable = 1'b1;
    have = 1'b0;
    @(negedge clk);
    g = 0;
    while (!bus.reqReady && g < 20) begin
      @(negedge clk);
      g++;
    end
    bus.reqWrite  = w;
    bus.reqSize   = sz;
    bus.reqSigned = sg;
    bus.reqAddr   = a;
    bus.reqWData  = wdat;
    bus.reqValid  = 1'b1;
    @(negedge clk);
    bus.reqValid  = 1'b0;
    bus.reqWData  = $urandom;
    for (int c = 1; c <= 8; c++) begin
      if (bus.memRead) o.nrd++;
      if (bus.memWrite) begin
        o.nwr++;
        o.wd = bus.memWData;
      end
      if (bus.memRead && bus.memWrite) o.both = 1'b1;
      if (bus.memRead || bus.memWrite) begin
        if (!have) begin
          o.maddr = 32'(bus.memAddr);
          have    = 1'b1;
        end else if (32'(bus.memAddr) != o.maddr) begin
          o.stable = 1'b0;
        end
      end
      if (bus.respValid) begin
        o.lat = c;
        o.err = bus.alignErr;
        o.ld  = bus.loadData;
        break;
      end
      @(negedge clk);
    end
    if (o.lat != 0) begin
      @(negedge clk);
      o.post_ok = !bus.respValid && bus.reqReady && !bus.memRead && !bus.memWrite;
    end
  endtask

  // Compare one observed access against its expectations.
  task automatic check_obs(input string tag, input obs_t o, input vec_t e);
    chk({tag, " latency"}, 32'(o.lat), 32'(e.lat));
    chk({tag, " alignErr"}, 32'(o.err), 32'(e.err));
    chk({tag, " loadData"}, o.ld, e.ld);
    chk({tag, " reads"}, 32'(o.nrd), 32'(e.nrd));
    chk({tag, " writes"}, 32'(o.nwr), 32'(e.nwr));
    if (e.nwr != 0) chk({tag, " memWData"}, o.wd, e.mwd);
    if (e.nrd + e.nwr != 0) begin
      chk({tag, " memAddr"}, o.maddr, e.a >> 2);
      chk({tag, " addr stable"}, 32'(o.stable), 32'd1);
    end
    chk({tag, " strobe overlap"}, 32'(o.both), 32'd0);
    chk({tag, " back to idle"}, 32'(o.post_ok), 32'd1);
  endtask

  // Fold an access into the reference model.
  task automatic model_apply(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wdat);
    if (!is_mis(sz, a)) begin
      if (w) ref_store(a, sz, wdat);
      else   ref_ld = ref_load(a, sz, sg);
    end
  endtask

  vec_t tbl [13];
  obs_t o;
  vec_t e;

  initial begin
    checks = 0;
    errors = 0;
    bus.reqValid  = 1'b0;
    bus.reqWrite  = 1'b0;
    bus.reqSize   = 2'd0;
    bus.reqSigned = 1'b0;
    bus.reqAddr   = 32'h0;
    bus.reqWData  = 32'h0;
    for (int i = 0; i < 256; i++) refm[i] = 8'h0;
    ref_ld = 32'h0;

    //        w     sz     sg    addr    wdata          lat err   loadData    rd wr memWData
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0000_0000, 0, 1, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        2, 1'b0, 32'hDEADBEEF, 1, 0, 32'h0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 2, 1'b0, 32'hDEADBEEF, 0, 1, 32'h11223344};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5, 3, 1'b0, 32'hDEADBEEF, 1, 1, 32'h1122A544};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        2, 1'b0, 32'hFFFFFFA5, 1, 0, 32'h0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        2, 1'b0, 32'h000000A5, 1, 0, 32'h0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80010000, 2, 1'b0, 32'h000000A5, 0, 1, 32'h80010000};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        2, 1'b0, 32'hFFFF8001, 1, 0, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        2, 1'b0, 32'h00008001, 1, 0, 32'h0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,        1, 1'b1, 32'h00008001, 0, 0, 32'h0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h01, 32'h0000BEEF, 1, 1'b1, 32'h00008001, 0, 0, 32'h0};
    tbl[11] = '{1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, 1, 1'b1, 32'h00008001, 0, 0, 32'h0};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        2, 1'b0, 32'h80010000, 1, 0, 32'h0};

    // Reset held for two cycles.
    reset   = 1'b1;
    mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    mem_clr = 1'b0;
    chk("reset reqReady", 32'(bus.reqReady), 32'd1);
    chk("reset memRead", 32'(bus.memRead), 32'd0);
    chk("reset memWrite", 32'(bus.memWrite), 32'd0);
    chk("reset respValid", 32'(bus.respValid), 32'd0);
    chk("reset alignErr", 32'(bus.alignErr), 32'd0);
    chk("reset loadData", bus.loadData, 32'h0);

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wdat, o);
      check_obs($sformatf("row%0d", i), o, tbl[i]);
      model_apply(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wdat);
    end
    chk("misaligned store left word 8", mem[8], 32'h0);
    chk("misaligned store left word 0", mem[0], 32'h0);

    // Reset during RMW_RD of a byte store: no write may follow.
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h55667788, o);
    chk("seed word latency", 32'(o.lat), 32'd2);
    model_apply(1'b1, 2'd2, 1'b0, 32'h40, 32'h55667788);
    @(negedge clk);
    bus.reqWrite = 1'b1;
    bus.reqSize  = 2'd0;
    bus.reqAddr  = 32'h41;
    bus.reqWData = 32'h000000EE;
    bus.reqValid = 1'b1;
    @(negedge clk);
    bus.reqValid = 1'b0;
    chk("rmw_rd memRead", 32'(bus.memRead), 32'd1);
    chk("rmw_rd memWrite", 32'(bus.memWrite), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort memWrite", 32'(bus.memWrite), 32'd0);
    chk("abort memRead", 32'(bus.memRead), 32'd0);
    chk("abort reqReady", 32'(bus.reqReady), 32'd1);
    chk("abort respValid", 32'(bus.respValid), 32'd0);
    chk("abort loadData", bus.loadData, 32'h0);
    ref_ld = 32'h0;
    @(negedge clk);
    chk("abort no late write", 32'(bus.memWrite), 32'd0);
    chk("abort word intact", mem[16], 32'h55667788);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, o);
    chk("abort reload", o.ld, 32'h55667788);
    model_apply(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

    // Randomized traffic against the byte-level reference model.
    for (int k = 0; k < 120; k++) begin
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      logic [31:0] wdat;
      bit          mis;
      w    = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      sg   = 1'($urandom_range(0, 1));
      a    = 32'($urandom_range(0, 255));
      wdat = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      mis = is_mis(sz, a);
      e.w    = w;
      e.sz   = sz;
      e.sg   = sg;
      e.a    = a;
      e.wdat = wdat;
      e.err  = mis;
      e.lat  = mis ? 1 : ((w && sz != 2'd2) ? 3 : 2);
      e.nrd  = mis ? 0 : ((!w || sz != 2'd2) ? 1 : 0);
      e.nwr  = (mis || !w) ? 0 : 1;
      do_req(w, sz, sg, a, wdat, o);
      model_apply(w, sz, sg, a, wdat);
      e.ld  = ref_ld;
      e.mwd = ref_word(int'(a >> 2));
      check_obs($sformatf("rand%0d", k), o, e);
    end

    // Whole memory must match the byte model.
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk($sformatf("final word %0d", i), mem[i], ref_word(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequencing ever wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
